// File: rtl/fp16_mac_accumulator.sv
// FP16 running-sum accumulator: acc = acc + product, one element per 5 cycles
// through an iterative ALIGN/ADD/NORM/RND sequence with RNE rounding.
module fp16_mac_accumulator #(
    parameter logic [15:0] ACC_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    input  logic        acc_clr,
    output logic [15:0] acc_out,
    output logic        out_valid,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_RND   = 3'd4;

    logic [2:0]        r_state;
    logic [15:0]       r_acc;
    logic              r_out_valid;
    logic [15:0]       r_a;
    logic [15:0]       r_b;
    logic              r_last;
    logic              r_spec;
    logic [15:0]       r_spec_val;
    logic              r_sgn;
    logic              r_sub;
    logic [4:0]        r_exp;
    logic [13:0]       r_big;
    logic [13:0]       r_small;
    logic [14:0]       r_sum;
    logic [13:0]       r_n;
    logic signed [6:0] r_nexp;
    logic              r_zero;

    function automatic logic [3:0] lzc14(input logic [13:0] v);
        lzc14 = 4'd14;
        for (int i = 0; i < 14; i++)
            if (v[i]) lzc14 = 4'(13 - i);
    endfunction

    // Operand unpack: subnormals flush to signed zero (exp 0, significand 0)
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [4:0]  w_ea, w_eb;
    logic [10:0] w_siga, w_sigb;
    logic [15:0] w_key_a, w_key_b;
    logic        w_swap;

    assign w_a_nan  = (&r_a[14:10]) && (|r_a[9:0]);
    assign w_b_nan  = (&r_b[14:10]) && (|r_b[9:0]);
    assign w_a_inf  = (&r_a[14:10]) && ~(|r_a[9:0]);
    assign w_b_inf  = (&r_b[14:10]) && ~(|r_b[9:0]);
    assign w_a_zero = ~(|r_a[14:10]);
    assign w_b_zero = ~(|r_b[14:10]);
    assign w_ea     = w_a_zero ? 5'd0 : r_a[14:10];
    assign w_eb     = w_b_zero ? 5'd0 : r_b[14:10];
    assign w_siga   = w_a_zero ? 11'd0 : {1'b1, r_a[9:0]};
    assign w_sigb   = w_b_zero ? 11'd0 : {1'b1, r_b[9:0]};
    assign w_key_a  = {w_ea, w_siga};
    assign w_key_b  = {w_eb, w_sigb};
    assign w_swap   = w_key_b > w_key_a;

    logic        w_big_sgn;
    logic [4:0]  w_big_exp, w_small_exp, w_diff;
    logic [10:0] w_big_sig, w_small_sig;
    logic [23:0] w_wide;
    logic [13:0] w_small_al;

    assign w_big_sgn   = w_swap ? r_b[15] : r_a[15];
    assign w_big_exp   = w_swap ? w_eb : w_ea;
    assign w_small_exp = w_swap ? w_ea : w_eb;
    assign w_big_sig   = w_swap ? w_sigb : w_siga;
    assign w_small_sig = w_swap ? w_siga : w_sigb;
    assign w_diff      = w_big_exp - w_small_exp;
    assign w_wide      = {w_small_sig, 13'd0} >> w_diff;
    // Field layout: 11-bit significand, guard, round, sticky
    assign w_small_al  = (w_diff > 5'd13) ? {13'd0, |w_small_sig}
                                          : {w_wide[23:11], |w_wide[10:0]};

    logic        w_spec;
    logic [15:0] w_spec_val;

    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = 16'h7E00;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[15] != r_b[15])))
            w_spec_val = 16'h7E00;
        else if (w_a_inf)
            w_spec_val = {r_a[15], 15'h7C00};
        else if (w_b_inf)
            w_spec_val = {r_b[15], 15'h7C00};
        else if (w_a_zero && w_b_zero)
            w_spec_val = {r_a[15] & r_b[15], 15'd0};
        else
            w_spec = 1'b0;
    end

    logic [3:0]        w_lz;
    logic [13:0]       w_norm_shift;
    logic signed [6:0] w_exp_ext;

    assign w_lz         = lzc14(r_sum[13:0]);
    assign w_norm_shift = r_sum[13:0] << w_lz;
    assign w_exp_ext    = $signed({2'b00, r_exp});

    logic              w_inc;
    logic [11:0]       w_rsig;
    logic signed [6:0] w_rexp;
    logic [9:0]        w_mant;
    logic [15:0]       w_result;

    assign w_inc  = r_n[2] & (r_n[1] | r_n[0] | r_n[3]);
    assign w_rsig = {1'b0, r_n[13:3]} + {11'd0, w_inc};
    assign w_rexp = r_nexp + (w_rsig[11] ? 7'sd1 : 7'sd0);
    assign w_mant = w_rsig[11] ? w_rsig[10:1] : w_rsig[9:0];

    always_comb begin
        w_result = {r_sgn, w_rexp[4:0], w_mant};
        if (r_spec)
            w_result = r_spec_val;
        else if (r_zero || (w_rexp < 7'sd1))
            w_result = 16'h0000;
        else if (w_rexp > 7'sd30)
            w_result = {r_sgn, 15'h7C00};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_acc       <= ACC_INIT;
            r_out_valid <= 1'b0;
            r_a         <= 16'd0;
            r_b         <= 16'd0;
            r_last      <= 1'b0;
            r_spec      <= 1'b0;
            r_spec_val  <= 16'd0;
            r_sgn       <= 1'b0;
            r_sub       <= 1'b0;
            r_exp       <= 5'd0;
            r_big       <= 14'd0;
            r_small     <= 14'd0;
            r_sum       <= 15'd0;
            r_n         <= 14'd0;
            r_nexp      <= 7'sd0;
            r_zero      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= acc_clr ? ACC_INIT : r_acc;
                        r_b     <= in_data;
                        r_last  <= in_last;
                        r_state <= S_ALIGN;
                    end else if (acc_clr) begin
                        r_acc <= ACC_INIT;
                    end
                end
                S_ALIGN: begin
                    r_spec     <= w_spec;
                    r_spec_val <= w_spec_val;
                    r_sgn      <= w_big_sgn;
                    r_sub      <= r_a[15] ^ r_b[15];
                    r_exp      <= w_big_exp;
                    r_big      <= {w_big_sig, 3'b000};
                    r_small    <= w_small_al;
                    r_state    <= S_ADD;
                end
                S_ADD: begin
                    // Larger magnitude is always r_big, so subtraction never underflows
                    r_sum   <= r_sub ? ({1'b0, r_big} - {1'b0, r_small})
                                     : ({1'b0, r_big} + {1'b0, r_small});
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_zero <= ~(|r_sum);
                    if (r_sum[14]) begin
                        r_n    <= {r_sum[14:2], |r_sum[1:0]};
                        r_nexp <= w_exp_ext + 7'sd1;
                    end else begin
                        r_n    <= w_norm_shift;
                        r_nexp <= w_exp_ext - $signed({3'b000, w_lz});
                    end
                    r_state <= S_RND;
                end
                S_RND: begin
                    r_acc       <= w_result;
                    r_out_valid <= r_last;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign acc_out   = r_acc;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fp16_mac_accumulator.sv
// Bench for fp16_mac_accumulator: directed vector table, multi-cycle corner
// sequences and random elements checked against a real-arithmetic model.
module tb_fp16_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        in_last = 1'b0;
    logic        acc_clr = 1'b0;
    logic [15:0] acc_out;
    logic        out_valid;
    logic        busy;

    int nchk = 0;
    int nbad = 0;

    fp16_mac_accumulator #(.ACC_INIT(16'h0000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .acc_clr(acc_clr),
        .acc_out(acc_out), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=time limit reached required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (plain real arithmetic) ----------------
    function automatic real to_real(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = real'(1024 + int'(h[9:0]));
        e = int'(h[14:10]) - 25;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] from_real(input real x);
        real m, r, fl, fr;
        int  e, ri, be;
        logic sg;
        if (x == 0.0) return 16'h0000;
        sg = (x < 0.0);
        m  = sg ? -x : x;
        e  = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        r  = m * 1024.0;
        fl = $floor(r);
        ri = int'(fl);
        fr = r - fl;
        if (fr > 0.5 || (fr == 0.5 && (ri % 2) == 1)) ri++;
        if (ri == 2048) begin ri = 1024; e++; end
        be = e + 15;
        if (be < 1)  return 16'h0000;
        if (be > 30) return {sg, 15'h7C00};
        return {sg, 5'(be), 10'(ri - 1024)};
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic an, bn, ai, bi, az, bz;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        az = (a[14:10] == 5'h00);
        bz = (b[14:10] == 5'h00);
        if (an || bn) return 16'h7E00;
        if (ai && bi) return (a[15] == b[15]) ? a : 16'h7E00;
        if (ai) return a;
        if (bi) return b;
        if (az && bz) return {a[15] & b[15], 15'd0};
        return from_real(to_real(a) + to_real(b));
    endfunction

    function automatic logic [15:0] rnd_fp();
        if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 7))
                0: return 16'h0000;
                1: return 16'h8000;
                2: return 16'h7C00;
                3: return 16'hFC00;
                4: return 16'h7E01;
                5: return 16'h0123;
                6: return 16'h7BFF;
                default: return 16'hFBFF;
            endcase
        end
        return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom_range(0, 1023))};
    endfunction

    // One element through the handshake, with latency/ready/out_valid checks
    task automatic push(input logic c, input logic [15:0] d, input logic l,
                        input logic [15:0] expv, input string nm);
        int t;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        chk({nm, ".ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = d; in_last = l; acc_clr = c;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; acc_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({nm, ".busy_rdy"}, {30'd0, in_ready, busy}, 32'b01);
            chk({nm, ".early_ov"}, 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk({nm, ".acc"}, 32'(acc_out), 32'(expv));
        chk({nm, ".ov"}, 32'(out_valid), 32'(l));
        @(posedge clk); #1;
        chk({nm, ".ov_pulse"}, 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic        clr;
        logic [15:0] d;
        logic        last;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[$];
    logic [15:0] m_acc, e;
    int   n_acc;
    logic stale;

    initial begin
        vt.push_back('{1'b1, 16'h3C00, 1'b0, 16'h3C00});
        vt.push_back('{1'b0, 16'h4000, 1'b1, 16'h4200});
        vt.push_back('{1'b1, 16'h4000, 1'b0, 16'h4000});
        vt.push_back('{1'b0, 16'hC000, 1'b1, 16'h0000});
        vt.push_back('{1'b1, 16'h3C00, 1'b0, 16'h3C00});
        vt.push_back('{1'b0, 16'h1000, 1'b0, 16'h3C00});
        vt.push_back('{1'b1, 16'h3C01, 1'b0, 16'h3C01});
        vt.push_back('{1'b0, 16'h1000, 1'b0, 16'h3C02});
        vt.push_back('{1'b1, 16'h0200, 1'b0, 16'h0000});
        vt.push_back('{1'b1, 16'h0400, 1'b0, 16'h0400});
        vt.push_back('{1'b0, 16'h8401, 1'b0, 16'h0000});
        vt.push_back('{1'b1, 16'h7C00, 1'b0, 16'h7C00});
        vt.push_back('{1'b0, 16'h3C00, 1'b0, 16'h7C00});
        vt.push_back('{1'b1, 16'h7E01, 1'b0, 16'h7E00});
        vt.push_back('{1'b1, 16'h7BFF, 1'b0, 16'h7BFF});
        vt.push_back('{1'b0, 16'h7BFF, 1'b0, 16'h7C00});
        vt.push_back('{1'b0, 16'hFC00, 1'b0, 16'h7E00});
        vt.push_back('{1'b0, 16'h3C00, 1'b1, 16'h7E00});

        #3;
        chk("rst.acc", 32'(acc_out), 32'h0);
        chk("rst.flags", {29'd0, in_ready, busy, out_valid}, 32'b100);
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < vt.size(); i++)
            push(vt[i].clr, vt[i].d, vt[i].last, vt[i].exp, $sformatf("vec%0d", i));

        // acc_clr with no element recovers from NaN
        @(negedge clk); acc_clr = 1'b1;
        @(posedge clk); #1; acc_clr = 1'b0;
        chk("clr_idle.acc", 32'(acc_out), 32'h0);
        chk("clr_idle.ov_busy", {30'd0, out_valid, busy}, 32'b00);

        // in_valid held high for 12 cycles: accepts only at edges 0, 5, 10
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            chk("b2b.ready_vs_busy", 32'(in_ready), 32'(!busy));
            if (in_ready) n_acc++;
            @(posedge clk);
            if (i < 11) @(negedge clk);
        end
        #1; in_valid = 1'b0;
        chk("b2b.accepts", 32'(n_acc), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b.acc", 32'(acc_out), 32'h4200);

        // reset asserted while in ADD
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        chk("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b0; #1;
        chk("midrst.acc", 32'(acc_out), 32'h0);
        chk("midrst.flags", {29'd0, in_ready, busy, out_valid}, 32'b100);
        @(negedge clk); rst = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            stale = stale | out_valid;
        end
        chk("midrst.no_stale_ov", 32'(stale), 32'd0);
        push(1'b0, 16'h3C00, 1'b1, 16'h3C00, "midrst.next");

        // random elements vs. model
        m_acc = 16'h3C00;
        for (int i = 0; i < 200; i++) begin
            logic c, l;
            logic [15:0] d;
            c = (i == 0) || ($urandom_range(0, 3) == 0);
            l = 1'($urandom_range(0, 1));
            d = rnd_fp();
            e = ref_add(c ? 16'h0000 : m_acc, d);
            push(c, d, l, e, $sformatf("rnd%0d(%h+%h)", i, c ? 16'h0000 : m_acc, d));
            m_acc = e;
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/fp16_mac_accumulator.md
Name: fp16_mac_accumulator

Overview:
- Downstream stage of the FP16 multiplier in the MAC datapath. Consumes the multiplier's IEEE-754 half-precision product stream and keeps a running FP16 sum, acc = acc + product.
- Uses an iterative 5-state add FSM, one element per 5 cycles. The upstream multiplier stalls or buffers through the in_valid/in_ready handshake.
- Emits the final dot-product result with a one-cycle out_valid pulse when the element tagged last has been accumulated.

Parameters:
ACC_INIT, 16'h0000, value loaded into the accumulator on reset and on acc_clr (FP16 encoding).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low (rst=0 resets immediately; released synchronously by the integrator).
in_valid  input  1  in_data/in_last are valid this cycle.
in_ready  output  1  block can accept an element this cycle.
in_data  input  16  FP16 product from the multiplier.
in_last  input  1  element is the final term of the current sum.
acc_clr  input  1  start a new sum; sampled only when in_ready=1.
acc_out  output  16  current accumulator value (registered).
out_valid  output  1  one-cycle pulse: acc_out holds the completed sum.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc_out=ACC_INIT, in_ready=1, out_valid=0, busy=0, last flag=0. Reset mid-operation aborts the element in flight; nothing is written back.
- FSM states: IDLE, ALIGN, ADD, NORM, RND.
- IDLE: in_ready=1, busy=0.
  - Accept occurs when in_valid & in_ready at edge k: latch operands and in_last, go to ALIGN.
  - acc_clr=1 at edge k with in_valid=0: acc_out <= ACC_INIT, stay IDLE.
  - acc_clr=1 with in_valid=1: the element is added to ACC_INIT instead of the old acc.
- ALIGN (edge k+1): unpack both operands to an 11-bit significand (hidden bit). Swap so the larger magnitude is first. Right-shift the smaller by the exponent difference into a 14-bit field (guard, round, sticky). If the difference exceeds 13, the smaller operand contributes sticky only.
- ADD (edge k+2): signed-magnitude add/subtract in 15 bits (carry bit). The result sign is the sign of the larger magnitude.
- NORM (edge k+3): carry out gives a right shift of 1 with exponent+1. Otherwise, left-shift by the leading-zero count with the exponent reduced to match.
- RND (edge k+4): round-to-nearest-even using guard/round/sticky. A mantissa overflow after rounding increments the exponent. acc_out is written at this edge and the FSM returns to IDLE.
  - in_ready=1 again from the cycle after edge k+4, giving a throughput of 1 element per 5 cycles.
- out_valid: high for exactly the one cycle after edge k+4 if the latched in_last=1; low otherwise. acc_out is not cleared automatically after last.
- in_ready=0 in all non-IDLE states. in_valid held high while busy is not re-accepted. acc_clr while busy is ignored.
- Special values:
  - Subnormal inputs are flushed to signed zero. A result whose exponent is below 1 after rounding becomes +0.
  - Exact cancellation gives +0 (0x0000). (-0)+(-0) gives 0x8000.
  - Exponent overflow gives signed Inf (0x7C00/0xFC00).
  - Inf + finite gives that Inf.
  - NaN input, or Inf + opposite-sign Inf, gives canonical NaN 0x7E00.
  - Once acc_out is NaN, it stays NaN until acc_clr or reset.

Test Plan:
- Reset then acc_clr. Accept 0x3C00 (in_last=0), then 0x4000 (in_last=1) -> after the second accept, acc_out=0x4200 (3.0) exactly 4 edges later, with out_valid high for one cycle. in_ready is low for 4 cycles after each accept.
- Cancellation: acc_clr with in_data=0x4000, then 0xC000 with in_last=1 -> acc_out=0x0000, out_valid pulse.
- Tie rounding, ties-to-even: acc 0x3C00 + 0x1000 -> 0x3C00. acc 0x3C01 + 0x1000 -> 0x3C02.
- Overflow and special values:
  - acc 0x7BFF + 0x7BFF -> 0x7C00.
  - Then +0xFC00 -> 0x7E00, and NaN persists on a further +0x3C00.
  - acc_clr recovers to 0x0000.
- Handshake and back-to-back: hold in_valid=1 with data 0x3C00 for 12 cycles -> exactly 3 accepts (edges 0, 5, 10), acc_out=0x4200. No accept while busy=1.
- Reset mid-op: assert rst=0 in the ADD state -> all outputs return to reset values immediately. After release, the next sum starts from 0x0000 with no stale out_valid.
